seg_scan: RTL and testbench

Time-multiplexed seven-segment scanner that sits directly downstream of the page display selector. It snapshots the five 4-bit digit codes the selector drives (positions 6..2) once per scan frame and drives one digit at a time onto a shared active-low segment bus. It inserts a dead-time between digits to suppress ghosting, and decodes BCD, blank (4'hF) and dash (4'hA–4'hE) codes.

---
 rtl/seg_scan.sv | 62 ++++++
 tb/tb_seg_scan.sv | 133 +++++++++++++
 2 files changed

// File: rtl/seg_scan.sv
// seg_scan: five-digit multiplexed seven-segment scanner with per-frame input snapshot and dead-time
module seg_scan #(
   parameter int DIV  = 1000,
   parameter int DEAD = 50
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [3:0] d6,
   input  logic [3:0] d5,
   input  logic [3:0] d4,
   input  logic [3:0] d3,
   input  logic [3:0] d2,
   output logic [4:0] an,
   output logic [6:0] seg,
   output logic       frame
);
   localparam int CW = $clog2(DIV);
   localparam logic [6:0] DEC [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
      7'b0111111, 7'b0111111, 7'b0111111, 7'b1111111
   };
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [2:0]      slot_q, slot_d;
   logic [4:0][3:0] sh_q, sh_d;
   logic [4:0]      an_q, an_d;
   logic [6:0]      seg_q, seg_d;
   logic            frame_q, frame_d;
   logic            last, dead;
   // snapshot entry 0 holds d6 so it lines up with slot 0
   always_comb begin
      last    = int'(cnt_q) == DIV - 1;
      dead    = int'(cnt_q) < DEAD;
      frame_d = last && slot_q == 3'd4;
      cnt_d   = last ? '0 : cnt_q + 1'b1;
      slot_d  = last ? (frame_d ? 3'd0 : slot_q + 3'd1) : slot_q;
      sh_d    = frame_d ? {d2, d3, d4, d5, d6} : sh_q;
      an_d    = dead ? 5'b11111 : ~(5'b10000 >> slot_q);
      seg_d   = dead ? 7'h7F : DEC[sh_q[slot_q]];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         slot_q  <= '0;
         sh_q    <= '1;
         an_q    <= '1;
         seg_q   <= '1;
         frame_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         slot_q  <= slot_d;
         sh_q    <= sh_d;
         an_q    <= an_d;
         seg_q   <= seg_d;
         frame_q <= frame_d;
      end
   end
   assign an    = an_q;
   assign seg   = seg_q;
   assign frame = frame_q;
endmodule

// File: tb/tb_seg_scan.sv
// tb_seg_scan: random-stimulus bench comparing two scanner configurations against a time-indexed model
module tb_seg_scan;
   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [3:0] d6, d5, d4, d3, d2;
   logic [4:0] an_a, an_b;
   logic [6:0] seg_a, seg_b;
   logic       frame_a, frame_b;
   int         n_run = 0;
   int         n_fail = 0;
   int         k = 0;
   int         lf_a = -1;
   int         lf_b = -1;
   logic [4:0][3:0] snap_a = '1;
   logic [4:0][3:0] snap_b = '1;
   localparam logic [6:0] SEGS [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
      7'b0111111, 7'b0111111, 7'b0111111, 7'b1111111
   };

   always #5 clk = ~clk;

   seg_scan #(.DIV(4), .DEAD(1)) u_a (
      .clk(clk), .rst_n(rst_n), .d6(d6), .d5(d5), .d4(d4), .d3(d3), .d2(d2),
      .an(an_a), .seg(seg_a), .frame(frame_a)
   );
   seg_scan #(.DIV(2), .DEAD(0)) u_b (
      .clk(clk), .rst_n(rst_n), .d6(d6), .d5(d5), .d4(d4), .d3(d3), .d2(d2),
      .an(an_b), .seg(seg_b), .frame(frame_b)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_run++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s at k=%0d: got %0h expected %0h", tag, k, obs, exp);
      end
   endtask

   // outputs after edge k (k counted from the first edge with reset released)
   function automatic logic [12:0] model(int div, int dead, int kk, logic [4:0][3:0] snap);
      int p;
      int s;
      logic fr;
      p  = kk % div;
      s  = (kk / div) % 5;
      fr = (kk % (5 * div)) == 5 * div - 1;
      if (p < dead) return {fr, 5'b11111, 7'b1111111};
      return {fr, ~(5'b00001 << (4 - s)), SEGS[snap[s]]};
   endfunction

   task automatic step();
      logic [12:0] ea, eb;
      @(posedge clk);
      ea = model(4, 1, k, snap_a);
      eb = model(2, 0, k, snap_b);
      if (k % 20 == 19) snap_a = {d2, d3, d4, d5, d6};
      if (k % 10 == 9)  snap_b = {d2, d3, d4, d5, d6};
      k++;
      #1;
      chk("an_a", an_a, ea[11:7]);
      chk("seg_a", seg_a, ea[6:0]);
      chk("frame_a", frame_a, ea[12]);
      chk("an_b", an_b, eb[11:7]);
      chk("seg_b", seg_b, eb[6:0]);
      chk("frame_b", frame_b, eb[12]);
      chk("onehot_a", $countones(~an_a) <= 1, 1);
      chk("onehot_b", $countones(~an_b) <= 1, 1);
      if (frame_a) begin
         if (lf_a >= 0) chk("gap_a", k - lf_a, 20);
         lf_a = k;
      end
      if (frame_b) begin
         if (lf_b >= 0) chk("gap_b", k - lf_b, 10);
         lf_b = k;
      end
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   // reset asserted between edges must blank outputs without waiting for a clock
   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_an_a", an_a, 5'b11111);
      chk("rst_seg_a", seg_a, 7'b1111111);
      chk("rst_frame_a", frame_a, 1'b0);
      chk("rst_an_b", an_b, 5'b11111);
      chk("rst_seg_b", seg_b, 7'b1111111);
      chk("rst_frame_b", frame_b, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      k      = 0;
      lf_a   = -1;
      lf_b   = -1;
      snap_a = '1;
      snap_b = '1;
   endtask

   initial begin
      {d6, d5, d4, d3, d2} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
      #1;
      do_reset();
      steps(30);
      d4 = 4'd8;
      steps(30);
      d5 = 4'hF;
      d4 = 4'hC;
      steps(40);
      while (k % 20 != 9) step();
      do_reset();
      steps(45);
      for (int i = 0; i < 20000; i++) begin
         if ($urandom_range(0, 6) == 0) begin
            case ($urandom_range(0, 4))
               0: d6 = 4'($urandom_range(0, 15));
               1: d5 = 4'($urandom_range(0, 15));
               2: d4 = 4'($urandom_range(0, 15));
               3: d3 = 4'($urandom_range(0, 15));
               default: d2 = 4'($urandom_range(0, 15));
            endcase
         end
         step();
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
